// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared rasterizer constants, point field layout and writer FSM states.
package gpu_pkg;

    localparam int DEF_SCREEN_WIDTH  = 640;
    localparam int DEF_SCREEN_HEIGHT = 480;
    localparam int DEF_COLOR_W       = 16;

    localparam int PT_W     = 32;
    localparam int PT_X_LSB = 0;
    localparam int PT_X_MSB = 15;
    localparam int PT_Y_LSB = 16;
    localparam int PT_Y_MSB = 31;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } wr_state_t;

    function automatic logic [31:0] coord32(input logic [15:0] c);
        return {16'd0, c};
    endfunction

endpackage

// File: rtl/point_fifo.sv
// rtl/point_fifo.sv - synchronous point FIFO; a push into a full FIFO is accepted when a pop shares the edge.
module point_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/point_fb_writer.sv
// rtl/point_fb_writer.sv - clips and buffers rasterized points, then issues framebuffer color writes over req/ack.
module point_fb_writer
    import gpu_pkg::*;
#(
    parameter  int          SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter  int          SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter  int          FIFO_DEPTH    = 16,
    parameter  logic [31:0] BASE_ADDR     = 32'h0,
    parameter  int          COLOR_W       = DEF_COLOR_W,
    localparam int          CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_write,
    input  logic [31:0]        i_point,
    input  logic [COLOR_W-1:0] i_color,
    output logic               o_mem_req,
    output logic [31:0]        o_mem_addr,
    output logic [COLOR_W-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    output logic               o_busy,
    output logic               o_clip,
    output logic               o_overflow,
    output logic [CW-1:0]      o_count
);

    localparam int EW = PT_W + COLOR_W;

    wr_state_t          state;
    logic [15:0]        in_x;
    logic [15:0]        in_y;
    logic               off_screen;
    logic               push;
    logic               pop;
    logic [EW-1:0]      head;
    logic [15:0]        head_x;
    logic [15:0]        head_y;
    logic [COLOR_W-1:0] head_color;
    logic [31:0]        head_addr;
    logic               fifo_full;
    logic               fifo_empty;

    assign in_x       = i_point[PT_X_MSB:PT_X_LSB];
    assign in_y       = i_point[PT_Y_MSB:PT_Y_LSB];
    assign off_screen = (coord32(in_x) >= 32'(SCREEN_WIDTH)) ||
                        (coord32(in_y) >= 32'(SCREEN_HEIGHT));
    assign push       = i_write && !off_screen;

    // A pop loads the next head into the output registers; in S_REQ that only happens on ack.
    assign pop = !fifo_empty && ((state == S_IDLE) || i_mem_ack);

    point_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  ({i_point, i_color}),
        .i_pop   (pop),
        .o_data  (head),
        .o_count (o_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign head_y     = head[COLOR_W+PT_Y_MSB:COLOR_W+PT_Y_LSB];
    assign head_x     = head[COLOR_W+PT_X_MSB:COLOR_W+PT_X_LSB];
    assign head_color = head[COLOR_W-1:0];
    assign head_addr  = BASE_ADDR + coord32(head_y) * 32'(SCREEN_WIDTH) + coord32(head_x);

    assign o_busy = (o_count != '0) || (state == S_REQ);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_mem_req   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_clip      <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_clip <= i_write && off_screen;
            if (push && fifo_full && !pop) begin
                o_overflow <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_mem_addr  <= head_addr;
                        o_mem_wdata <= head_color;
                        o_mem_req   <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_ack) begin
                        if (pop) begin
                            o_mem_addr  <= head_addr;
                            o_mem_wdata <= head_color;
                        end else begin
                            o_mem_req <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    o_mem_req <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_point_fb_writer.sv
// tb/tb_point_fb_writer.sv - table-driven and sequence checks for point_fb_writer.
module tb_point_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [31:0] point;
    logic [15:0] color;
    logic        req;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic        busy;
    logic        clip;
    logic        ovf;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    point_fb_writer #(
        .SCREEN_WIDTH  (640),
        .SCREEN_HEIGHT (480),
        .FIFO_DEPTH    (16),
        .BASE_ADDR     (32'h0),
        .COLOR_W       (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_write     (write),
        .i_point     (point),
        .i_color     (color),
        .o_mem_req   (req),
        .o_mem_addr  (addr),
        .o_mem_wdata (wdata),
        .i_mem_ack   (ack),
        .o_busy      (busy),
        .o_clip      (clip),
        .o_overflow  (ovf),
        .o_count     (count)
    );

    logic [31:0] log_addr [0:511];
    logic [15:0] log_data [0:511];
    int          wr_n = 0;

    always @(posedge clk) begin
        if (!rst && req && ack) begin
            if (wr_n < 512) begin
                log_addr[wr_n] = addr;
                log_data[wr_n] = wdata;
            end
            wr_n++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic push_pt(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
        write = 1'b1;
        point = {y, x};
        color = c;
        tick();
        write = 1'b0;
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] color;
        logic        on_screen;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int base;
        int max_cnt;
        int ovf_seen;

        vecs[0] = '{16'd3,     16'd2,     16'hABCD, 1'b1, 32'd1283};
        vecs[1] = '{16'd640,   16'd0,     16'h1111, 1'b0, 32'd0};
        vecs[2] = '{16'd0,     16'd480,   16'h2222, 1'b0, 32'd0};
        vecs[3] = '{16'd639,   16'd479,   16'h3333, 1'b1, 32'd307199};
        vecs[4] = '{16'd0,     16'd0,     16'h4444, 1'b1, 32'd0};
        vecs[5] = '{16'd65535, 16'd65535, 16'h5555, 1'b0, 32'd0};
        vecs[6] = '{16'd639,   16'd0,     16'h6666, 1'b1, 32'd639};
        vecs[7] = '{16'd0,     16'd479,   16'h7777, 1'b1, 32'd306560};

        rst   = 1'b1;
        write = 1'b0;
        point = '0;
        color = '0;
        ack   = 1'b0;
        tick();
        tick();
        check("rst_req",   {31'd0, req},   32'd0);
        check("rst_addr",  addr,           32'd0);
        check("rst_wdata", {16'd0, wdata}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_clip",  {31'd0, clip},  32'd0);
        check("rst_ovf",   {31'd0, ovf},   32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        rst = 1'b0;
        tick();

        // Single points with ack tied high: N+1 count/clip, N+2 request, N+3 idle.
        ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            base = wr_n;
            push_pt(vecs[i].x, vecs[i].y, vecs[i].color);
            check("vec_clip",  {31'd0, clip},  {31'd0, !vecs[i].on_screen});
            check("vec_count", {27'd0, count}, {31'd0, vecs[i].on_screen});
            tick();
            check("vec_req",   {31'd0, req},   {31'd0, vecs[i].on_screen});
            check("vec_clip2", {31'd0, clip},  32'd0);
            if (vecs[i].on_screen) begin
                check("vec_addr",  addr,           vecs[i].exp_addr);
                check("vec_wdata", {16'd0, wdata}, {16'd0, vecs[i].color});
            end
            tick();
            check("vec_req_off", {31'd0, req},  32'd0);
            check("vec_busy",    {31'd0, busy}, 32'd0);
            check("vec_writes",  wr_n - base,   {31'd0, vecs[i].on_screen});
        end

        // Continuous stream along row 5.
        base = wr_n;
        max_cnt = 0;
        ovf_seen = 0;
        for (int i = 0; i < 100; i++) begin
            push_pt(16'(i), 16'd5, 16'(i * 3));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (ovf) ovf_seen = 1;
        end
        wait_idle(50);
        check("stream_count_le2", {31'd0, (max_cnt <= 2)}, 32'd1);
        check("stream_ovf",       ovf_seen,                32'd0);
        check("stream_writes",    wr_n - base,             32'd100);
        for (int i = 0; i < 100; i++) begin
            check("stream_addr", log_addr[base + i],          32'(3200 + i));
            check("stream_data", {16'd0, log_data[base + i]}, {16'd0, 16'(i * 3)});
        end

        // Stall: one held on the port, sixteen queued, three dropped.
        ack = 1'b0;
        base = wr_n;
        for (int i = 0; i < 20; i++) begin
            push_pt(16'(10 + i), 16'd7, 16'(16'h1000 + i));
        end
        check("stall_count", {27'd0, count}, 32'd16);
        check("stall_ovf",   {31'd0, ovf},   32'd1);
        check("stall_req",   {31'd0, req},   32'd1);
        check("stall_addr",  addr,           32'd4490);
        tick();
        tick();
        check("stall_addr_hold", addr,           32'd4490);
        check("stall_data_hold", {16'd0, wdata}, 32'h1000);
        ack = 1'b1;
        wait_idle(40);
        check("stall_writes", wr_n - base, 32'd17);
        for (int i = 0; i < 17; i++) begin
            check("stall_log_addr", log_addr[base + i],          32'(4490 + i));
            check("stall_log_data", {16'd0, log_data[base + i]}, 32'(32'h1000 + i));
        end
        check("ovf_sticky", {31'd0, ovf}, 32'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("ovf_cleared", {31'd0, ovf}, 32'd0);

        // Full FIFO with simultaneous push and pop.
        ack = 1'b0;
        base = wr_n;
        for (int i = 0; i < 17; i++) begin
            push_pt(16'(i), 16'd20, 16'(16'h2000 + i));
        end
        check("full_count", {27'd0, count}, 32'd16);
        check("full_ovf",   {31'd0, ovf},   32'd0);
        ack = 1'b1;
        push_pt(16'd100, 16'd20, 16'hBEEF);
        check("pp_count", {27'd0, count}, 32'd16);
        check("pp_ovf",   {31'd0, ovf},   32'd0);
        wait_idle(40);
        check("pp_writes",     wr_n - base,                  32'd18);
        check("pp_first_addr", log_addr[base],               32'd12800);
        check("pp_last_addr",  log_addr[base + 17],          32'd12900);
        check("pp_last_data",  {16'd0, log_data[base + 17]}, 32'h0000BEEF);
        check("pp_ovf_end",    {31'd0, ovf},                 32'd0);

        // Reset with a write outstanding and five queued.
        ack = 1'b0;
        base = wr_n;
        for (int i = 0; i < 6; i++) begin
            push_pt(16'(i), 16'd30, 16'(16'h3000 + i));
        end
        check("mid_count", {27'd0, count}, 32'd5);
        check("mid_req",   {31'd0, req},   32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req",   {31'd0, req},   32'd0);
        check("mid_rst_count", {27'd0, count}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy},  32'd0);
        ack = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mid_no_writes", wr_n - base,  32'd0);
        check("mid_ovf",       {31'd0, ovf}, 32'd0);
        push_pt(16'd7, 16'd1, 16'h5A5A);
        wait_idle(10);
        check("post_writes", wr_n - base, 32'd1);
        check("post_addr",   log_addr[base],               32'd647);
        check("post_data",   {16'd0, log_data[base]},      32'h00005A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/point_fb_writer.md
# point_fb_writer

Downstream stage of the triangle rasterizer's point generator. Accepts one rasterized `{y, x}` pixel point per cycle on a pulse interface that has no backpressure, and buffers the points in a FIFO. Each point is converted to a linear framebuffer address and issued as a color write on a req/ack memory port that may stall. Reports overflow and clipping so the triangle sequencer can tell when a triangle has been fully committed to memory.

## Interface
Parameters:
- `SCREEN_WIDTH`, 640, pixels per row; address stride.
- `SCREEN_HEIGHT`, 480, rows; points with y ≥ this are clipped.
- `FIFO_DEPTH`, 16, point FIFO entries; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0, framebuffer base (pixel units).
- `COLOR_W`, 16, pixel color width.

Ports:
- `i_clk`  in  1  clock; all state on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_write`  in  1  point strobe; one point per cycle when high.
- `i_point`  in  32  `{y[15:0], x[15:0]}`, unsigned integer pixel coordinates.
- `i_color`  in  COLOR_W  color, sampled together with `i_point` on push.
- `o_mem_req`  out  1  write request.
- `o_mem_addr`  out  32  pixel address.
- `o_mem_wdata`  out  COLOR_W  pixel color.
- `i_mem_ack`  in  1  write accepted at this edge when `o_mem_req` is also high.
- `o_busy`  out  1  FIFO non-empty or a request is outstanding.
- `o_clip`  out  1  one-cycle pulse: a point was dropped as off-screen.
- `o_overflow`  out  1  sticky: a point was dropped because the FIFO was full.
- `o_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- **Push.** Occurs at an edge with `i_write`=1.
  - Off-screen point (x ≥ `SCREEN_WIDTH` or y ≥ `SCREEN_HEIGHT`): not stored; `o_clip`=1 next cycle.
  - Otherwise stored as `{y, x, color}`, provided count < `FIFO_DEPTH` or a pop happens at the same edge.
  - Full FIFO with no pop at that edge: point dropped; `o_overflow` set. It clears only on reset.
- **FSM, `S_IDLE`.** If count > 0: pop the head, register the address and color, go to `S_REQ`. Otherwise stay.
- **FSM, `S_REQ`.**
  - `o_mem_req`=1. Address and data are held stable until an edge with `i_mem_ack`=1.
  - On ack with count > 0: pop the next entry at the same edge and stay in `S_REQ` (back-to-back writes).
  - On ack with the FIFO empty: return to `S_IDLE`.
- **Address.** `BASE_ADDR + y*SCREEN_WIDTH + x`, computed as unsigned 32-bit and truncated to 32 bits. x and y are zero-extended. `SCREEN_WIDTH` is a constant multiplier.
- **Busy.** `o_busy` = (count ≠ 0) || (state == `S_REQ`).
- **Ordering.** Memory writes occur in strict push order; no reordering or coalescing.

## Timing
- **Reset values.**
  - `o_mem_req`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
  - `o_busy`=0, `o_clip`=0, `o_overflow`=0, `o_count`=0.
  - FSM in `S_IDLE`, FIFO pointers at 0.
- **Latency.** `i_write` in cycle N → `o_count`=1 in cycle N+1 → `o_mem_req`=1 with the correct address in cycle N+2.
- **Throughput.** With `i_mem_ack` tied high: one write per cycle, and the FIFO never exceeds 2 entries under a continuous 1-point/cycle push.
- **Simultaneous push and pop when full.** Both happen; count is unchanged and there is no overflow.
- **Simultaneous push and pop when empty.** Not possible: a pop requires count > 0 before the edge. A point pushed to an empty FIFO is popped one edge later.
- **`i_mem_ack` while `o_mem_req`=0.** Ignored.
- **Count wrap-around.** Pointers wrap modulo `FIFO_DEPTH`. `o_count` saturates at `FIFO_DEPTH`, which is the full indication.
- **Reset mid-operation.** `o_mem_req` drops asynchronously. The FIFO contents are discarded and the outstanding write is abandoned.

## Structure
- Shared package `gpu_pkg`:
  - `SCREEN_WIDTH` and `SCREEN_HEIGHT` defaults.
  - Point field positions (x [15:0], y [31:16]).
  - Default `COLOR_W`.
  - Shared with the point generator and the triangle sequencer.
- Sub-module `point_fifo`: synchronous FIFO with push/pop/count, width 32+`COLOR_W`, depth `FIFO_DEPTH`, and same-edge push+pop when full.
- The top level holds the clip check, the FSM and the address computation.

## Test plan
- **Single point.** Point (x=3, y=2), color 16'hABCD, ack tied high → one write, addr = 2*640+3 = 1283, wdata = ABCD. `o_mem_req` is high in cycle N+2 only, and `o_busy` is low from N+3.
- **Continuous stream.** 100 consecutive points along row y=5, x=0..99, ack=1 → 100 writes to addresses 3200..3299 in order. `o_count` ≤ 2 and `o_overflow`=0 throughout.
- **Stall and overflow.** `FIFO_DEPTH`=16, ack=0, push 20 points.
  - The first point stays held on the memory port and 16 more fill the FIFO.
  - Points 18–20 are dropped and `o_overflow`=1.
  - Releasing ack yields exactly 17 writes, in order.
- **Clip.** Push (640, 0), (0, 480) and (639, 479) → two `o_clip` pulses; a single write to addr 479*640+639 = 307199.
- **Full push+pop.** With the FIFO full and ack=1 in the same cycle as `i_write` → count stays 16, `o_overflow` stays 0, and the new point is written last.
- **Reset mid-stream.** Assert `i_rst` with 5 queued points and `o_mem_req` high → `o_mem_req` goes low immediately with no further writes, `o_count`=0, `o_overflow`=0. A new point after release is written normally.
